// File: rtl/tofpet_csr_pkg.sv
// Shared constants for the TofPet readout CSR slave: word map,
// identification value and the empty-pop marker.
package tofpet_csr_pkg;

    localparam int MAX_CH = 16;

    localparam logic [31:0] ID_VALUE       = 32'hF1CA_CA02;
    localparam logic [31:0] UNDERFLOW_MARK = 32'hDEAD_0000;

    localparam logic [5:0] A_EMPTY      = 6'h10;
    localparam logic [5:0] A_FULL       = 6'h11;
    localparam logic [5:0] A_OVF        = 6'h12;
    localparam logic [5:0] A_ID         = 6'h13;
    localparam logic [5:0] A_CTRL_OUT   = 6'h14;
    localparam logic [5:0] A_CTRL_IN    = 6'h15;
    localparam logic [5:0] A_NBIT       = 6'h16;
    localparam logic [5:0] A_COMMAND    = 6'h17;
    localparam logic [5:0] A_STATUS     = 6'h18;
    localparam logic [5:0] A_IRQ_MASK   = 6'h19;
    localparam logic [5:0] A_THRESH     = 6'h1A;
    localparam logic [5:0] A_IRQ_STAT   = 6'h1B;
    localparam logic [5:0] A_MERGED     = 6'h1C;
    localparam logic [5:0] A_LAST_CH    = 6'h1D;
    localparam logic [5:0] A_UNDERFLOW  = 6'h1E;
    localparam logic [5:0] A_USEDW_BASE = 6'h20;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tofpet_rr_arbiter.sv
// Rotating-priority encoder: lowest request at or after ptr wins,
// wrapping modulo N.
module tofpet_rr_arbiter #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [PW-1:0] idx;

    // Walk from farthest to nearest so the nearest request overwrites last.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                gnt_idx   = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tofpet_readout_csr.sv
// Avalon-MM slave for N TofPet readout FIFOs and the control FIFO pair,
// with registered reads, merged round-robin pop and interrupt logic.
module tofpet_readout_csr
    import tofpet_csr_pkg::*;
#(
    parameter int N_CH    = 6,
    parameter int DATA_W  = 32,
    parameter int USEDW_W = 11
) (
    input  logic                    CK,
    input  logic                    RESETb,
    input  logic [N_CH*DATA_W-1:0]  CH_DATA,
    input  logic [N_CH-1:0]         CH_EMPTY,
    input  logic [N_CH-1:0]         CH_FULL,
    input  logic [N_CH*USEDW_W-1:0] CH_USEDW,
    output logic [N_CH-1:0]         CH_READ,
    input  logic [DATA_W-1:0]       CTRL_FIFO_OUT,
    output logic                    CTRL_FIFO_OUT_RE,
    output logic [DATA_W-1:0]       CTRL_FIFO_IN,
    output logic                    CTRL_FIFO_IN_WE,
    output logic [31:0]             NBIT_INOUT,
    output logic [31:0]             COMMAND,
    input  logic [31:0]             STATUS_WORD,
    input  logic [5:0]              avs_address,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    input  logic                    avs_write,
    output logic [31:0]             avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest,
    output logic                    IRQ
);

    localparam int PW = ptr_w(N_CH);

    logic [31:0]       ch_data  [MAX_CH];
    logic [31:0]       ch_usedw [MAX_CH];
    logic [MAX_CH-1:0] ch_empty;

    for (genvar k = 0; k < MAX_CH; k++) begin : g_ch
        if (k < N_CH) begin : g_on
            assign ch_data[k]  = 32'(CH_DATA[k*DATA_W +: DATA_W]);
            assign ch_usedw[k] = 32'(CH_USEDW[k*USEDW_W +: USEDW_W]);
            assign ch_empty[k] = CH_EMPTY[k];
        end else begin : g_off
            assign ch_data[k]  = '0;
            assign ch_usedw[k] = '0;
            assign ch_empty[k] = 1'b1;
        end
    end

    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        nbit_q, nbit_d;
    logic [31:0]        command_q, command_d;
    logic [N_CH-1:0]    irq_mask_q, irq_mask_d;
    logic [USEDW_W-1:0] thresh_q, thresh_d;
    logic [N_CH-1:0]    ovf_q, ovf_d;
    logic [31:0]        underflow_q, underflow_d;
    logic [31:0]        last_ch_q, last_ch_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               irq_q, irq_d;

    logic            rd, wr;
    logic [3:0]      ch_sel;
    logic            ch_ok;
    logic            pop_sel, pop_merged, underflow_inc;
    logic [N_CH-1:0] ovf_clr;
    logic [N_CH-1:0] irq_stat;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_valid;

    // Strobes and read acceptance are held off while reset is asserted.
    assign rd     = avs_read & RESETb;
    assign wr     = avs_write & RESETb;
    assign ch_sel = avs_address[3:0];
    assign ch_ok  = int'(ch_sel) < N_CH;

    tofpet_rr_arbiter #(
        .N  (N_CH),
        .PW (PW)
    ) u_arb (
        .req       (~CH_EMPTY),
        .ptr       (rr_ptr_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        irq_stat = '0;
        for (int k = 0; k < N_CH; k++) begin
            irq_stat[k] = (thresh_q != '0) &&
                          (CH_USEDW[k*USEDW_W +: USEDW_W] >= thresh_q);
        end
    end

    always_comb begin
        rdata_d          = '0;
        rvalid_d         = rd;
        nbit_d           = nbit_q;
        command_d        = command_q;
        irq_mask_d       = irq_mask_q;
        thresh_d         = thresh_q;
        underflow_d      = underflow_q;
        last_ch_d        = last_ch_q;
        rr_ptr_d         = rr_ptr_q;
        ovf_clr          = '0;
        pop_sel          = 1'b0;
        pop_merged       = 1'b0;
        underflow_inc    = 1'b0;
        CTRL_FIFO_OUT_RE = 1'b0;

        if (rd) begin
            if (avs_address >= A_USEDW_BASE) begin
                if (int'(avs_address[4:0]) < N_CH) begin
                    rdata_d = ch_usedw[avs_address[3:0]];
                end
            end else if (!avs_address[4]) begin
                if (ch_ok) begin
                    if (ch_empty[ch_sel]) begin
                        rdata_d       = UNDERFLOW_MARK | 32'(ch_sel);
                        underflow_inc = 1'b1;
                    end else begin
                        rdata_d = ch_data[ch_sel];
                        pop_sel = 1'b1;
                    end
                end
            end else begin
                case (avs_address)
                    A_EMPTY:     rdata_d = 32'(CH_EMPTY);
                    A_FULL:      rdata_d = 32'(CH_FULL);
                    A_OVF:       rdata_d = 32'(ovf_q);
                    A_ID:        rdata_d = ID_VALUE;
                    A_CTRL_OUT: begin
                        rdata_d          = 32'(CTRL_FIFO_OUT);
                        CTRL_FIFO_OUT_RE = 1'b1;
                    end
                    A_NBIT:      rdata_d = nbit_q;
                    A_COMMAND:   rdata_d = command_q;
                    A_STATUS:    rdata_d = STATUS_WORD;
                    A_IRQ_MASK:  rdata_d = 32'(irq_mask_q);
                    A_THRESH:    rdata_d = 32'(thresh_q);
                    A_IRQ_STAT:  rdata_d = 32'(irq_stat);
                    A_MERGED: begin
                        if (gnt_valid) begin
                            rdata_d    = ch_data[4'(gnt_idx)];
                            pop_merged = 1'b1;
                            last_ch_d  = {1'b1, 27'b0, 4'(gnt_idx)};
                            rr_ptr_d   = (gnt_idx == PW'(N_CH - 1)) ?
                                         '0 : gnt_idx + PW'(1);
                        end else begin
                            last_ch_d = '0;
                        end
                    end
                    A_LAST_CH:   rdata_d = last_ch_q;
                    A_UNDERFLOW: rdata_d = underflow_q;
                    default:     rdata_d = '0;
                endcase
            end
        end

        if (wr) begin
            case (avs_address)
                A_OVF:       ovf_clr     = avs_writedata[N_CH-1:0];
                A_NBIT:      nbit_d      = avs_writedata;
                A_COMMAND:   command_d   = avs_writedata;
                A_IRQ_MASK:  irq_mask_d  = avs_writedata[N_CH-1:0];
                A_THRESH:    thresh_d    = avs_writedata[USEDW_W-1:0];
                A_UNDERFLOW: underflow_d = '0;
                default:     ;
            endcase
        end

        // A live FULL flag re-arms OVF in the same cycle it is cleared.
        ovf_d = (ovf_q & ~ovf_clr) | CH_FULL;
        if (underflow_inc && underflow_d != '1) begin
            underflow_d = underflow_d + 32'd1;
        end
        irq_d = (|(irq_stat & irq_mask_q)) | (|(ovf_q & irq_mask_q));
    end

    always_comb begin
        CH_READ = '0;
        for (int k = 0; k < N_CH; k++) begin
            CH_READ[k] = (pop_sel && ch_sel == 4'(k)) ||
                         (pop_merged && gnt_idx == PW'(k));
        end
    end

    always_ff @(posedge CK) begin
        if (!RESETb) begin
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            nbit_q      <= '0;
            command_q   <= '0;
            irq_mask_q  <= '0;
            thresh_q    <= '0;
            ovf_q       <= '0;
            underflow_q <= '0;
            last_ch_q   <= '0;
            rr_ptr_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            nbit_q      <= nbit_d;
            command_q   <= command_d;
            irq_mask_q  <= irq_mask_d;
            thresh_q    <= thresh_d;
            ovf_q       <= ovf_d;
            underflow_q <= underflow_d;
            last_ch_q   <= last_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            irq_q       <= irq_d;
        end
    end

    assign CTRL_FIFO_IN      = DATA_W'(avs_writedata);
    assign CTRL_FIFO_IN_WE   = wr && (avs_address == A_CTRL_IN);
    assign NBIT_INOUT        = nbit_q;
    assign COMMAND           = command_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_waitrequest   = 1'b0;
    assign IRQ               = irq_q;

endmodule

// File: tb/tb_tofpet_readout_csr.sv
// Scoreboard bench for tofpet_readout_csr: queue-based FIFO and register
// model predicts read data, strobes and IRQ.
module tb_tofpet_readout_csr;

    localparam int N  = 6;
    localparam int UW = 11;

    logic CK = 1'b0;
    always #5 CK = ~CK;

    logic            RESETb;
    logic [N*32-1:0] CH_DATA;
    logic [N-1:0]    CH_EMPTY, CH_FULL, CH_READ;
    logic [N*UW-1:0] CH_USEDW;
    logic [31:0]     CTRL_FIFO_OUT, CTRL_FIFO_IN;
    logic            CTRL_FIFO_OUT_RE, CTRL_FIFO_IN_WE;
    logic [31:0]     NBIT_INOUT, COMMAND, STATUS_WORD;
    logic [5:0]      avs_address;
    logic [31:0]     avs_writedata, avs_readdata;
    logic            avs_read, avs_write, avs_readdatavalid;
    logic            avs_waitrequest, IRQ;

    tofpet_readout_csr #(
        .N_CH(N), .DATA_W(32), .USEDW_W(UW)
    ) dut (
        .CK(CK), .RESETb(RESETb),
        .CH_DATA(CH_DATA), .CH_EMPTY(CH_EMPTY), .CH_FULL(CH_FULL),
        .CH_USEDW(CH_USEDW), .CH_READ(CH_READ),
        .CTRL_FIFO_OUT(CTRL_FIFO_OUT), .CTRL_FIFO_OUT_RE(CTRL_FIFO_OUT_RE),
        .CTRL_FIFO_IN(CTRL_FIFO_IN), .CTRL_FIFO_IN_WE(CTRL_FIFO_IN_WE),
        .NBIT_INOUT(NBIT_INOUT), .COMMAND(COMMAND),
        .STATUS_WORD(STATUS_WORD),
        .avs_address(avs_address), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_write(avs_write),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest(avs_waitrequest), .IRQ(IRQ)
    );

    // Environment FIFOs and reference register state
    logic [31:0] chq [N][$];
    int          usedw [N];
    logic [N-1:0] full_v;
    logic [31:0] nbit_m, cmd_m, last_m, und_m;
    logic [N-1:0] ovf_m, mask_m;
    int          thr_m, rr_m;
    bit          irq_m, irq_known, prev_rst, rnd_env;
    logic [31:0] sb [$];
    int          checks = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CK) begin
        if (avs_readdatavalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rvalid: got rdata %h expected no response",
                         avs_readdata);
            end else begin
                chk("readdata", avs_readdata, sb.pop_front());
            end
        end else if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL missing_rvalid: got valid 0 expected 1 (data %h)", sb[0]);
            sb.delete();
        end
    end

    function automatic logic [N-1:0] stat_m();
        logic [N-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s[k] = (thr_m != 0) && (usedw[k] >= thr_m);
        return s;
    endfunction

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            CH_EMPTY[k]          = (chq[k].size() == 0);
            CH_DATA[k*32 +: 32]  = (chq[k].size() != 0) ? chq[k][0] : 32'h0;
            CH_USEDW[k*UW +: UW] = UW'(usedw[k]);
        end
        CH_FULL = full_v;
    endtask

    task automatic reset_model();
        nbit_m = 0; cmd_m = 0; last_m = 0; und_m = 0;
        ovf_m = 0; mask_m = 0; thr_m = 0; rr_m = 0; irq_m = 0;
    endtask

    task automatic predict(input logic [5:0] a, output logic [31:0] d,
                           output logic [N-1:0] pop);
        int  k;
        bit  found;
        d = '0;
        pop = '0;
        k = int'(a[4:0]);
        if (a < 6'h10) begin
            if (k < N) begin
                if (chq[k].size() != 0) begin
                    d = chq[k][0];
                    pop[k] = 1'b1;
                end else begin
                    d = 32'hDEAD_0000 + 32'(k);
                    if (und_m != 32'hFFFF_FFFF) und_m = und_m + 1;
                end
            end
        end else if (a >= 6'h20) begin
            if (k < N) d = 32'(usedw[k]);
        end else begin
            case (a)
                6'h10: for (int i = 0; i < N; i++) d[i] = (chq[i].size() == 0);
                6'h11: d = 32'(full_v);
                6'h12: d = 32'(ovf_m);
                6'h13: d = 32'hF1CA_CA02;
                6'h14: d = CTRL_FIFO_OUT;
                6'h16: d = nbit_m;
                6'h17: d = cmd_m;
                6'h18: d = STATUS_WORD;
                6'h19: d = 32'(mask_m);
                6'h1A: d = 32'(thr_m);
                6'h1B: d = 32'(stat_m());
                6'h1C: begin
                    found = 0;
                    for (int i = 0; i < N; i++) begin
                        int j;
                        j = (rr_m + i) % N;
                        if (!found && chq[j].size() != 0) begin
                            found = 1;
                            d = chq[j][0];
                            pop[j] = 1'b1;
                            last_m = 32'h8000_0000 | 32'(j);
                            rr_m = (j + 1) % N;
                        end
                    end
                    if (!found) last_m = 0;
                end
                6'h1D: d = last_m;
                6'h1E: d = und_m;
                default: d = '0;
            endcase
        end
    endtask

    task automatic step(input bit rd, input bit wr, input logic [5:0] a,
                        input logic [31:0] wd, input bit rst);
        logic [31:0]  d;
        logic [N-1:0] pop;
        bit           irqn, re, we;
        @(negedge CK);
        if (irq_known) begin
            chk("irq", 32'(IRQ), 32'(irq_m));
            chk("command_out", COMMAND, cmd_m);
            chk("nbit_out", NBIT_INOUT, nbit_m);
        end
        if (prev_rst) begin
            chk("rst_rvalid", 32'(avs_readdatavalid), 32'h0);
            chk("rst_rdata", avs_readdata, 32'h0);
        end
        if (rnd_env) begin
            for (int k = 0; k < N; k++) begin
                full_v[k] = ($urandom_range(0, 19) == 0);
                usedw[k] = $urandom_range(0, 150);
            end
            STATUS_WORD = $urandom;
            CTRL_FIFO_OUT = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                int c;
                c = $urandom_range(0, N - 1);
                if (chq[c].size() < 6) chq[c].push_back($urandom);
            end
        end
        RESETb = !rst;
        avs_read = rd;
        avs_write = wr;
        avs_address = a;
        avs_writedata = wd;
        refresh();
        d = '0;
        pop = '0;
        if (!rst && rd) predict(a, d, pop);
        irqn = (|(stat_m() & mask_m)) || (|(ovf_m & mask_m));
        re = !rst && rd && (a == 6'h14);
        we = !rst && wr && (a == 6'h15);
        #1;
        chk("ch_read", 32'(CH_READ), 32'(pop));
        chk("ctrl_out_re", 32'(CTRL_FIFO_OUT_RE), 32'(re));
        chk("ctrl_in_we", 32'(CTRL_FIFO_IN_WE), 32'(we));
        if (we) chk("ctrl_in_data", CTRL_FIFO_IN, wd);
        if (!rst && rd) sb.push_back(d);
        @(posedge CK);
        if (rst) begin
            reset_model();
            irq_known = 1;
        end else begin
            for (int k = 0; k < N; k++) if (pop[k]) void'(chq[k].pop_front());
            if (wr) begin
                case (a)
                    6'h12: ovf_m = ovf_m & ~wd[N-1:0];
                    6'h16: nbit_m = wd;
                    6'h17: cmd_m = wd;
                    6'h19: mask_m = wd[N-1:0];
                    6'h1A: thr_m = int'(wd[UW-1:0]);
                    6'h1E: und_m = 0;
                    default: ;
                endcase
            end
            ovf_m = ovf_m | full_v;
            irq_m = irqn;
        end
        prev_rst = rst;
    endtask

    task automatic rd_(input logic [5:0] a);
        step(1, 0, a, 0, 0);
    endtask

    task automatic wr_(input logic [5:0] a, input logic [31:0] wd);
        step(0, 1, a, wd, 0);
    endtask

    task automatic idle();
        step(0, 0, 6'h0, 0, 0);
    endtask

    initial begin
        RESETb = 0; avs_read = 0; avs_write = 0;
        avs_address = 0; avs_writedata = 0;
        full_v = 0; STATUS_WORD = 32'h5A5A_0F0F; CTRL_FIFO_OUT = 32'hC0DE_0001;
        for (int k = 0; k < N; k++) usedw[k] = 0;
        reset_model();
        irq_known = 0; prev_rst = 0; rnd_env = 0;
        refresh();

        repeat (3) step(0, 0, 6'h0, 0, 1);
        // reset state of the register file
        rd_(6'h17); rd_(6'h16); rd_(6'h12); rd_(6'h1D); rd_(6'h1E);
        rd_(6'h19); rd_(6'h1A); rd_(6'h13); rd_(6'h10); rd_(6'h18);

        // single-channel pop and underflow
        chq[2].push_back(32'hA5A5_0001);
        rd_(6'h02);
        idle();
        rd_(6'h03);
        rd_(6'h1E);
        wr_(6'h1E, 32'h0);
        rd_(6'h1E);
        rd_(6'h07);
        rd_(6'h14);
        wr_(6'h15, 32'h0BAD_CAFE);

        // merged round-robin pop
        chq[1].push_back(32'h1111_0001);
        chq[4].push_back(32'h4444_0004);
        rd_(6'h1C); rd_(6'h1D);
        rd_(6'h1C); rd_(6'h1D);
        rd_(6'h1C); rd_(6'h1D); rd_(6'h1E);

        // usedw threshold interrupt
        wr_(6'h1A, 32'd100);
        wr_(6'h19, 32'h01);
        usedw[0] = 99;
        idle(); idle();
        usedw[0] = 100;
        idle(); idle(); rd_(6'h1B); rd_(6'h20);
        wr_(6'h1A, 32'd0);
        idle(); idle();

        // sticky overflow with write-1-to-clear
        full_v[5] = 1'b1; idle();
        full_v[5] = 1'b0; rd_(6'h12);
        full_v[5] = 1'b1; wr_(6'h12, 32'h20); rd_(6'h12);
        full_v[5] = 1'b0; idle(); wr_(6'h12, 32'h20); rd_(6'h12);

        // write then reset mid-read
        wr_(6'h17, 32'h1234);
        rd_(6'h17);
        step(1, 0, 6'h17, 0, 1);
        rd_(6'h17);
        rd_(6'h12);

        rnd_env = 1;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0]  a;
            logic [31:0] wd;
            bit          r, w, x;
            case ($urandom_range(0, 3))
                0: a = 6'($urandom_range(0, 7));
                1: a = 6'h1C;
                2: a = 6'($urandom_range(16, 31));
                default: a = 6'($urandom_range(0, 63));
            endcase
            r = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 4) == 0);
            wd = (a == 6'h1A) ? 32'($urandom_range(0, 150)) : $urandom;
            x = ($urandom_range(0, 999) == 0);
            step(r, w, a, wd, x);
        end

        rnd_env = 0;
        idle(); idle();
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
